// File: rtl/rvdff_pipe_pkg.sv
// Shared definitions for the rvdff_pipe elastic pipeline register.
package rvdff_pipe_pkg;

  // Occupancy counter width: it must hold 0..DEPTH+1, the extra value
  // covering the optional skid entry.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/rvdff_pipe_stage.sv
// One valid/data register of the elastic pipe. Valid clears on rst or clr_i;
// data clears only on rst and otherwise changes only when the stage loads.
module rvdff_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q;
  logic             v_d;
  logic [WIDTH-1:0] d_q;

  // Next valid: squash wins over load, hold otherwise.
  always_comb begin
    v_d = v_q;
    if (clr_i)     v_d = 1'b0;
    else if (ld_i) v_d = v_i;
  end

  // Valid register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) v_q <= 1'b0;
    else     v_q <= v_d;
  end

  // Payload register; reset to zero, otherwise loads only with the stage.
  always_ff @(posedge clk) begin
    if (rst)       d_q <= '0;
    else if (ld_i) d_q <= d_i;
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/rvdff_pipe.sv
// Elastic pipeline register: WIDTH-bit payload through DEPTH stages with
// valid/ready flow control, bubble collapsing, flush and occupancy count.
// Optional feature macro: RVDFF_PIPE_SKID_EN adds a one-entry input skid
// buffer so in_ready comes straight from a flop.
module rvdff_pipe
  import rvdff_pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             s0_v_d;
  logic [WIDTH-1:0] s0_d_d;
  logic             in_xfer;
  logic             out_xfer;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Stage i may advance when any stage from i to the output is empty or the
  // output drains; written flat instead of as a chain to avoid a
  // self-referencing vector.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      adv[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!v_q[j]) adv[i] = 1'b1;
      end
    end
  end

`ifdef RVDFF_PIPE_SKID_EN
  logic             skid_v_q;
  logic [WIDTH-1:0] skid_d_q;
  logic             skid_ld;

  assign in_ready = !rst && !flush && !skid_v_q;
  assign in_xfer  = in_valid && in_ready;
  // Fill the skid only when stage 0 cannot take the accepted word; drain it
  // as soon as stage 0 advances.
  assign skid_ld  = skid_v_q ? adv[0] : (in_xfer && !adv[0]);

  rvdff_pipe_stage #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .ld_i  (skid_ld),
    .v_i   (!skid_v_q),
    .d_i   (in_data),
    .v_o   (skid_v_q),
    .d_o   (skid_d_q)
  );

  // Skid content has priority into stage 0; in_ready is low while it is full.
  assign s0_v_d = skid_v_q || in_xfer;
  assign s0_d_d = skid_v_q ? skid_d_q : in_data;
`else
  assign in_ready = !rst && !flush && adv[0];
  assign in_xfer  = in_valid && in_ready;
  assign s0_v_d   = in_xfer;
  assign s0_d_d   = in_data;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      rvdff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .ld_i  (adv[i]),
        .v_i   (s0_v_d),
        .d_i   (s0_d_d),
        .v_o   (v_q[i]),
        .d_o   (d_q[i])
      );
    end else begin : g_next
      rvdff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .ld_i  (adv[i]),
        .v_i   (v_q[i-1]),
        .d_i   (d_q[i-1]),
        .v_o   (v_q[i]),
        .d_o   (d_q[i])
      );
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_xfer  = out_valid && out_ready;

  // Occupancy follows the transfers on each side.
  always_comb begin
    count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
  end

  // Occupancy register; flush empties everything, so the count drops to 0.
  always_ff @(posedge clk) begin
    if (rst || flush) count_q <= '0;
    else              count_q <= count_d;
  end

  assign count = count_q;

endmodule
